// File: rtl/clock_div_multi_if.sv
// ----------------------------------------------------------------------------
// clock_div_multi_if
// Configuration-write channel for clock_div_multi. Carries a ready/valid
// handshake that selects one divider channel and supplies its new ratio.
//
// Signals
//   cfg_valid  master -> slave  configuration write request
//   cfg_ready  slave -> master  write can be accepted this cycle
//   cfg_chan   master -> slave  target channel index (CHAN_W bits)
//   cfg_div    master -> slave  new division ratio (DIV_WIDTH bits)
//
// Modports
//   master  drives the request (test sequencer / CPU side)
//   slave   the divider block
// ----------------------------------------------------------------------------
interface clock_div_multi_if #(
    parameter int N_CHAN    = 4,
    parameter int DIV_WIDTH = 16,
    parameter int CHAN_W    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHAN_W-1:0]    cfg_chan;
    logic [DIV_WIDTH-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clock_div_multi.sv
// ----------------------------------------------------------------------------
// clock_div_multi
// Multi-channel programmable clock divider. Each channel divides clk_in by an
// arbitrary integer ratio d >= 2 (high ceil(d/2), low floor(d/2) cycles).
// A ratio below 2 stops the channel low. New ratios are staged in a shadow
// register and only applied at a period boundary, so outputs never glitch.
// A sync pulse restarts every running channel in phase.
//
// Ports
//   clk_in   in   reference clock, all logic on posedge
//   rst      in   asynchronous active-high reset
//   cfg      slave modport of clock_div_multi_if (valid/ready/chan/div)
//   sync     in   one-cycle pulse, restarts all running channels
//   pending  out  per channel: accepted ratio not yet applied
//   clk_out  out  registered divided clocks
//   clk_stb  out  one-cycle pulse on each 0->1 of clk_out (optional)
//
// Optional feature macro: CLOCK_DIV_MULTI_STROBE_EN
//   When defined, adds clk_stb[N_CHAN-1:0]; a sync-forced restart also
//   produces a strobe even if clk_out was already high.
// ----------------------------------------------------------------------------
module clock_div_multi #(
    parameter int N_CHAN    = 4,
    parameter int DIV_WIDTH = 16,
    localparam int CHAN_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst,
    clock_div_multi_if.slave       cfg,
    input  logic                   sync,
    output logic [N_CHAN-1:0]      pending,
    output logic [N_CHAN-1:0]      clk_out
`ifdef CLOCK_DIV_MULTI_STROBE_EN
    ,
    output logic [N_CHAN-1:0]      clk_stb
`endif
);

    logic [DIV_WIDTH-1:0] shadow_q [N_CHAN];
    logic [DIV_WIDTH-1:0] shadow_d [N_CHAN];
    logic [DIV_WIDTH-1:0] active_q [N_CHAN];
    logic [DIV_WIDTH-1:0] active_d [N_CHAN];
    logic [DIV_WIDTH-1:0] cnt_q    [N_CHAN];
    logic [DIV_WIDTH-1:0] cnt_d    [N_CHAN];
    logic [DIV_WIDTH:0]   half     [N_CHAN];
    logic [DIV_WIDTH:0]   cnt_inc  [N_CHAN];
    logic [N_CHAN-1:0]    pending_q, pending_d;
    logic [N_CHAN-1:0]    q_q, q_d;
    logic [N_CHAN-1:0]    running, boundary, apply, accept;
    logic                 ready;

    // Ready reflects only the addressed channel; out-of-range indices never
    // match a channel, so they stay ready and the write is dropped.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < N_CHAN; i++) begin
            if (cfg.cfg_chan == CHAN_W'(i)) begin
                ready = !pending_q[i];
            end
        end
    end

    assign cfg.cfg_ready = ready;

    // Per-channel next state. A stopped channel is always at a boundary, so
    // a pending ratio on it is applied on the very next edge. Sync forces a
    // boundary on running channels only.
    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            running[i]  = (active_q[i] >= DIV_WIDTH'(2));
            boundary[i] = !running[i] || (cnt_q[i] == active_q[i] - DIV_WIDTH'(1));
            apply[i]    = pending_q[i] && (boundary[i] || sync);
            accept[i]   = cfg.cfg_valid && ready && (cfg.cfg_chan == CHAN_W'(i));
            half[i]     = ({1'b0, active_q[i]} + (DIV_WIDTH + 1)'(1)) >> 1;
            cnt_inc[i]  = {1'b0, cnt_q[i]} + (DIV_WIDTH + 1)'(1);

            shadow_d[i]  = accept[i] ? cfg.cfg_div : shadow_q[i];
            pending_d[i] = accept[i] || (pending_q[i] && !apply[i]);
            active_d[i]  = active_q[i];

            if (apply[i]) begin
                active_d[i] = shadow_q[i];
                cnt_d[i]    = '0;
                q_d[i]      = (shadow_q[i] >= DIV_WIDTH'(2));
            end else if (running[i] && (boundary[i] || sync)) begin
                cnt_d[i] = '0;
                q_d[i]   = 1'b1;
            end else if (running[i]) begin
                cnt_d[i] = cnt_inc[i][DIV_WIDTH-1:0];
                q_d[i]   = (cnt_inc[i] < half[i]);
            end else begin
                cnt_d[i] = '0;
                q_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CHAN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            pending_q <= '0;
            q_q       <= '0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            pending_q <= pending_d;
            q_q       <= q_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = q_q;

`ifdef CLOCK_DIV_MULTI_STROBE_EN
    logic [N_CHAN-1:0] stb_q, stb_d;

    // A sync restart strobes even when the output was already high, since
    // downstream logic treats it as the start of a new period.
    always_comb begin
        for (int i = 0; i < N_CHAN; i++) begin
            stb_d[i] = q_d[i] && (!q_q[i] || (sync && running[i]));
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stb_q <= '0;
        end else begin
            stb_q <= stb_d;
        end
    end

    assign clk_stb = stb_q;
`endif

endmodule
